// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter and DataMemory:
// FSM state encoding, owner codes, access width codes and the command payload.
package dmem_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WIDTH_W = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } dmem_state_e;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_L = 1'b1
    } dmem_owner_e;

    typedef enum logic [WIDTH_W-1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } dmem_width_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [WIDTH_W-1:0] width;
    } dmem_cmd_t;

endpackage

// File: rtl/dmem_starve_counter.sv
// Counts consecutive arbitrations the loader loses and forces a loader grant
// once the count reaches STARVE_MAX.
module dmem_starve_counter
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic l_req,
    input  logic l_win,
    output logic force_l_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Only IDLE cycles update the count; ISSUE/RD_WAIT hold it.
    always_comb begin
        cnt_d = cnt_q;
        if (arb_en) begin
            if (!l_req || l_win) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_W'(STARVE_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_l_c = (cnt_q == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single DataMemory port between the pipeline MEM stage (P) and the
// loader (L): one outstanding access, fixed read latency, starvation-bounded.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned LAT        = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               P_Req,
    input  logic               P_Write,
    input  logic [ADDR_W-1:0]  P_Addr,
    input  logic [DATA_W-1:0]  P_WData,
    input  logic [WIDTH_W-1:0] P_Width,
    output logic               P_Stall,
    output logic [DATA_W-1:0]  P_RData,
    output logic               P_RValid,
    input  logic               L_Req,
    input  logic               L_Write,
    input  logic [ADDR_W-1:0]  L_Addr,
    input  logic [DATA_W-1:0]  L_WData,
    input  logic [WIDTH_W-1:0] L_Width,
    output logic               L_Done,
    output logic [DATA_W-1:0]  L_RData,
    output logic               M_R_Enable,
    output logic               M_W_Enable,
    output logic [ADDR_W-1:0]  M_Addr,
    output logic [DATA_W-1:0]  M_WData,
    output logic [WIDTH_W-1:0] M_R_Width,
    output logic [WIDTH_W-1:0] M_W_Width,
    input  logic [DATA_W-1:0]  M_RData
);

    dmem_state_e        state_q, state_d;
    dmem_owner_e        owner_q, owner_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic               m_r_en_q, m_r_en_d;
    logic               m_w_en_q, m_w_en_d;
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic [DATA_W-1:0]  m_wdata_q, m_wdata_d;
    logic [WIDTH_W-1:0] m_r_width_q, m_r_width_d;
    logic [WIDTH_W-1:0] m_w_width_q, m_w_width_d;

    dmem_cmd_t p_cmd, l_cmd, sel_cmd;
    logic      l_win_c;
    logic      force_l_c;
    logic      done_c;
    logic      rd_done_c;

    assign p_cmd = '{write: P_Write, addr: P_Addr, wdata: P_WData, width: P_Width};
    assign l_cmd = '{write: L_Write, addr: L_Addr, wdata: L_WData, width: L_Width};

    dmem_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (Clock),
        .rst_n     (Reset),
        .arb_en    (state_q == IDLE),
        .l_req     (L_Req),
        .l_win     (l_win_c),
        .force_l_c (force_l_c)
    );

    // Next state, arbitration and memory command capture.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        m_r_en_d    = 1'b0;
        m_w_en_d    = 1'b0;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_r_width_d = m_r_width_q;
        m_w_width_d = m_w_width_q;
        l_win_c     = 1'b0;
        sel_cmd     = p_cmd;

        case (state_q)
            IDLE: begin
                if (P_Req || L_Req) begin
                    l_win_c     = L_Req && (!P_Req || force_l_c);
                    sel_cmd     = l_win_c ? l_cmd : p_cmd;
                    owner_d     = l_win_c ? OWN_L : OWN_P;
                    m_r_en_d    = !sel_cmd.write;
                    m_w_en_d    = sel_cmd.write;
                    m_addr_d    = sel_cmd.addr;
                    m_wdata_d   = sel_cmd.wdata;
                    m_r_width_d = sel_cmd.write ? WIDTH_W'(0) : sel_cmd.width;
                    m_w_width_d = sel_cmd.write ? sel_cmd.width : WIDTH_W'(0);
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (m_w_en_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RD_WAIT;
                    lat_d   = CNT_W'(LAT - 1);
                end
            end
            RD_WAIT: begin
                if (lat_q == '0) begin
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_P;
            lat_q       <= '0;
            m_r_en_q    <= 1'b0;
            m_w_en_q    <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_r_width_q <= '0;
            m_w_width_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            m_r_en_q    <= m_r_en_d;
            m_w_en_q    <= m_w_en_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_r_width_q <= m_r_width_d;
            m_w_width_q <= m_w_width_d;
        end
    end

    // Completion is decoded from state so read data can pass straight through.
    assign rd_done_c = (state_q == RD_WAIT) && (lat_q == '0);
    assign done_c    = rd_done_c || ((state_q == ISSUE) && m_w_en_q);

    assign P_RValid = rd_done_c && (owner_q == OWN_P);
    assign P_RData  = P_RValid ? M_RData : '0;
    assign P_Stall  = P_Req && !(done_c && (owner_q == OWN_P));
    assign L_Done   = done_c && (owner_q == OWN_L);
    assign L_RData  = (rd_done_c && (owner_q == OWN_L)) ? M_RData : '0;

    assign M_R_Enable = m_r_en_q;
    assign M_W_Enable = m_w_en_q;
    assign M_Addr     = m_addr_q;
    assign M_WData    = m_wdata_q;
    assign M_R_Width  = m_r_width_q;
    assign M_W_Width  = m_w_width_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (LAT=1 and LAT=3) driven from
// request queues and compared cycle by cycle against a transaction-level schedule.
module tb_dmem_port_arbiter;

    localparam int unsigned LAT0   = 1;
    localparam int unsigned LAT1   = 3;
    localparam int unsigned STARVE = 4;
    localparam int          MAXC   = 3000;
    localparam logic [31:0] JUNK   = 32'hA5A5_5A5A;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;

    logic        p_req[2], p_write[2], l_req[2], l_write[2];
    logic [31:0] p_addr[2], p_wdata[2], l_addr[2], l_wdata[2];
    logic [1:0]  p_width[2], l_width[2];
    logic        p_stall[2], p_rvalid[2], l_done[2];
    logic [31:0] p_rdata[2], l_rdata[2];
    logic        m_re[2], m_we[2];
    logic [31:0] m_addr[2], m_wdata[2], m_rdata[2];
    logic [1:0]  m_rw[2], m_ww[2];

    bit [31:0] pmem[2][256];
    bit [31:0] mmem[2][256];
    bit [31:0] rbuf[2];
    int        rcnt[2];

    int checks = 0;
    int errors = 0;

    txn_t pq[$];
    txn_t lq[$];
    int          obs_issue_c, obs_done_c, obs_prv, obs_prv_before_l;
    logic [31:0] obs_prdata, obs_ldata;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.LAT(LAT0), .STARVE_MAX(STARVE)) u_lat1 (
        .Clock(clk), .Reset(rst_n),
        .P_Req(p_req[0]), .P_Write(p_write[0]), .P_Addr(p_addr[0]), .P_WData(p_wdata[0]),
        .P_Width(p_width[0]), .P_Stall(p_stall[0]), .P_RData(p_rdata[0]), .P_RValid(p_rvalid[0]),
        .L_Req(l_req[0]), .L_Write(l_write[0]), .L_Addr(l_addr[0]), .L_WData(l_wdata[0]),
        .L_Width(l_width[0]), .L_Done(l_done[0]), .L_RData(l_rdata[0]),
        .M_R_Enable(m_re[0]), .M_W_Enable(m_we[0]), .M_Addr(m_addr[0]), .M_WData(m_wdata[0]),
        .M_R_Width(m_rw[0]), .M_W_Width(m_ww[0]), .M_RData(m_rdata[0])
    );

    dmem_port_arbiter #(.LAT(LAT1), .STARVE_MAX(STARVE)) u_lat3 (
        .Clock(clk), .Reset(rst_n),
        .P_Req(p_req[1]), .P_Write(p_write[1]), .P_Addr(p_addr[1]), .P_WData(p_wdata[1]),
        .P_Width(p_width[1]), .P_Stall(p_stall[1]), .P_RData(p_rdata[1]), .P_RValid(p_rvalid[1]),
        .L_Req(l_req[1]), .L_Write(l_write[1]), .L_Addr(l_addr[1]), .L_WData(l_wdata[1]),
        .L_Width(l_width[1]), .L_Done(l_done[1]), .L_RData(l_rdata[1]),
        .M_R_Enable(m_re[1]), .M_W_Enable(m_we[1]), .M_Addr(m_addr[1]), .M_WData(m_wdata[1]),
        .M_R_Width(m_rw[1]), .M_W_Width(m_ww[1]), .M_RData(m_rdata[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    // DataMemory model: data is valid exactly LAT cycles after the issue cycle.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_we[d]) pmem[d][m_addr[d][9:2]] <= m_wdata[d];
            if (m_re[d]) begin
                rcnt[d] <= lat_of(d);
                rbuf[d] <= pmem[d][m_addr[d][9:2]];
            end else if (rcnt[d] != 0) begin
                rcnt[d] <= rcnt[d] - 1;
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            m_rdata[d] = (rcnt[d] == 1) ? rbuf[d] : JUNK;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input bit wr, input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        t.wr = wr; t.addr = a; t.wdata = wd; t.width = 2'd2;
        return t;
    endfunction

    task automatic drive_idle(input int d);
        p_req[d] = 1'b0; p_write[d] = 1'b0; p_addr[d] = '0; p_wdata[d] = '0; p_width[d] = '0;
        l_req[d] = 1'b0; l_write[d] = 1'b0; l_addr[d] = '0; l_wdata[d] = '0; l_width[d] = '0;
    endtask

    // Runs pq/lq to completion on instance d; each requester holds its head
    // request until the scheduled completion cycle, then presents the next one.
    task automatic run(input int d, input string tag);
        int   sc, c, issue_c, comp_c, lat;
        bit   busy, own_l, issue_now, done_now, pr, lr, exp_prv, exp_ld;
        txn_t cur;
        logic [31:0] exp_rd;
        lat = lat_of(d); sc = 0; c = 0; busy = 0; own_l = 0; issue_c = 0; comp_c = 0;
        cur = mk(1'b0, 32'h0, 32'h0);
        obs_prv = 0; obs_prv_before_l = -1;
        while ((pq.size() > 0 || lq.size() > 0 || busy) && c < MAXC) begin
            pr = pq.size() > 0;
            lr = lq.size() > 0;
            p_req[d] = pr; l_req[d] = lr;
            if (pr) begin
                p_write[d] = pq[0].wr; p_addr[d] = pq[0].addr;
                p_wdata[d] = pq[0].wdata; p_width[d] = pq[0].width;
            end
            if (lr) begin
                l_write[d] = lq[0].wr; l_addr[d] = lq[0].addr;
                l_wdata[d] = lq[0].wdata; l_width[d] = lq[0].width;
            end
            @(negedge clk);
            issue_now = busy && (c == issue_c);
            done_now  = busy && (c == comp_c);
            exp_rd    = mmem[d][cur.addr[9:2]];
            exp_prv   = done_now && !own_l && !cur.wr;
            exp_ld    = done_now && own_l;
            check({tag, ".p_stall"}, 32'(p_stall[d]), 32'(pr && !(done_now && !own_l)));
            check({tag, ".p_rvalid"}, 32'(p_rvalid[d]), 32'(exp_prv));
            check({tag, ".p_rdata"}, p_rdata[d], exp_prv ? exp_rd : 32'h0);
            check({tag, ".l_done"}, 32'(l_done[d]), 32'(exp_ld));
            check({tag, ".l_rdata"}, l_rdata[d], (exp_ld && !cur.wr) ? exp_rd : 32'h0);
            check({tag, ".m_r_en"}, 32'(m_re[d]), 32'(issue_now && !cur.wr));
            check({tag, ".m_w_en"}, 32'(m_we[d]), 32'(issue_now && cur.wr));
            if (issue_now) begin
                check({tag, ".m_addr"}, m_addr[d], cur.addr);
                if (cur.wr) begin
                    check({tag, ".m_wdata"}, m_wdata[d], cur.wdata);
                    check({tag, ".m_w_width"}, 32'(m_ww[d]), 32'(cur.width));
                end else begin
                    check({tag, ".m_r_width"}, 32'(m_rw[d]), 32'(cur.width));
                end
            end
            if (m_re[d]) obs_issue_c = c;
            if (p_rvalid[d]) begin
                obs_done_c = c; obs_prdata = p_rdata[d]; obs_prv++;
            end
            if (l_done[d]) begin
                obs_done_c = c; obs_ldata = l_rdata[d]; obs_prv_before_l = obs_prv;
            end
            if (done_now) begin
                if (cur.wr) mmem[d][cur.addr[9:2]] = cur.wdata;
                if (own_l) void'(lq.pop_front());
                else void'(pq.pop_front());
                busy = 0;
            end else if (!busy) begin
                if (pr || lr) begin
                    own_l = lr && (!pr || sc == int'(STARVE));
                    if (own_l || !lr) sc = 0;
                    else if (sc < int'(STARVE)) sc++;
                    cur     = own_l ? lq[0] : pq[0];
                    busy    = 1;
                    issue_c = c + 1;
                    comp_c  = cur.wr ? c + 1 : c + 1 + lat;
                end else begin
                    sc = 0;
                end
            end
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= MAXC) begin
            checks++; errors++;
            $error("FAIL %s.timeout observed=%0d cycles expected=<%0d", tag, c, MAXC);
            pq.delete(); lq.delete();
        end
        drive_idle(d);
    endtask

    task automatic check_reset_outputs(input int d, input string tag);
        check({tag, ".m_r_en"}, 32'(m_re[d]), 32'h0);
        check({tag, ".m_w_en"}, 32'(m_we[d]), 32'h0);
        check({tag, ".m_addr"}, m_addr[d], 32'h0);
        check({tag, ".m_wdata"}, m_wdata[d], 32'h0);
        check({tag, ".m_widths"}, 32'({m_rw[d], m_ww[d]}), 32'h0);
        check({tag, ".p_rvalid"}, 32'(p_rvalid[d]), 32'h0);
        check({tag, ".l_done"}, 32'(l_done[d]), 32'h0);
        check({tag, ".rdata"}, p_rdata[d] | l_rdata[d], 32'h0);
        check({tag, ".p_stall"}, 32'(p_stall[d]), 32'(p_req[d]));
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle(0);
        drive_idle(1);
        #2;
        check_reset_outputs(0, "reset0");
        check_reset_outputs(1, "reset1");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload 0x10 through the loader, then a lone P load sees it one cycle after issue.
        lq.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF));
        run(0, "preload");
        pq.push_back(mk(1'b0, 32'h10, 32'h0));
        run(0, "p_load");
        check("p_load.data", obs_prdata, 32'hDEAD_BEEF);
        check("p_load.latency", 32'(obs_done_c - obs_issue_c), 32'd1);

        pq.push_back(mk(1'b1, 32'h20, 32'h1234_5678));
        pq.push_back(mk(1'b0, 32'h20, 32'h0));
        run(0, "p_store_load");
        check("p_store_load.data", obs_prdata, 32'h1234_5678);

        // P holds its request for six loads; L must win the fifth arbitration.
        for (int i = 0; i < 6; i++) pq.push_back(mk(1'b0, 32'h10, 32'h0));
        lq.push_back(mk(1'b0, 32'h20, 32'h0));
        run(0, "starve");
        check("starve.p_wins_before_l", 32'(obs_prv_before_l), 32'(STARVE));
        check("starve.l_data", obs_ldata, 32'h1234_5678);

        lq.push_back(mk(1'b1, 32'h40, 32'hCAFE_F00D));
        run(1, "lat3_fill");
        lq.push_back(mk(1'b0, 32'h40, 32'h0));
        run(1, "lat3_read");
        check("lat3_read.data", obs_ldata, 32'hCAFE_F00D);
        check("lat3_read.latency", 32'(obs_done_c - obs_issue_c), 32'd3);

        pq.push_back(mk(1'b1, 32'h30, 32'h1111_1111));
        lq.push_back(mk(1'b1, 32'h30, 32'h2222_2222));
        run(0, "dual_store");
        pq.push_back(mk(1'b0, 32'h30, 32'h0));
        run(0, "dual_store_rd");
        check("dual_store.final", obs_prdata, 32'h2222_2222);

        // Reset asserted while a LAT=3 load sits in RD_WAIT.
        p_req[1] = 1'b1; p_write[1] = 1'b0; p_addr[1] = 32'h40; p_width[1] = 2'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(1, "midreset");
        p_req[1] = 1'b0;
        #1;
        check("midreset.stall_follows", 32'(p_stall[1]), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midreset.no_done", 32'({p_rvalid[1], l_done[1]}), 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        pq.push_back(mk(1'b0, 32'h40, 32'h0));
        run(1, "post_reset");
        check("post_reset.data", obs_prdata, 32'hCAFE_F00D);

        // Randomised mixes of P and L traffic on both latencies.
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 25; r++) begin
                int np, nl;
                np = int'($urandom_range(0, 5));
                nl = int'($urandom_range(0, 3));
                for (int i = 0; i < np; i++) begin
                    txn_t t;
                    t = mk(1'($urandom_range(0, 1)), 32'(32'h100 + 4 * $urandom_range(0, 15)), $urandom);
                    t.width = 2'($urandom_range(0, 2));
                    pq.push_back(t);
                end
                for (int i = 0; i < nl; i++) begin
                    txn_t t;
                    t = mk(1'($urandom_range(0, 1)), 32'(32'h100 + 4 * $urandom_range(0, 15)), $urandom);
                    t.width = 2'($urandom_range(0, 2));
                    lq.push_back(t);
                end
                run(d, (d == 0) ? "rand_lat1" : "rand_lat3");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences and shares the single data-memory port between two requesters: the pipeline MEM stage (P, load/store) and a program/data loader (L, fills or dumps memory).
- Sits between those requesters and DataMemory.
- Serialises accesses and models a fixed read latency.
- Stalls the pipeline until its access completes, and prevents loader starvation with a bounded-wait counter.

Parameters:
- LAT, 1, DataMemory read latency in cycles from the issue cycle to valid M_RData (legal 1..15).
- STARVE_MAX, 4, number of consecutive lost arbitrations by L before L is forced to win (legal 1..15).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- P_Req  in  1  pipeline MEM stage access request (R_Enable|W_Enable); held stable until completion.
- P_Write  in  1  1 = store, 0 = load.
- P_Addr  in  32  byte address (ALUResult).
- P_WData  in  32  store data (Reg_Data2).
- P_Width  in  2  access width code, passed through unchanged.
- P_Stall  out  1  freeze the pipeline; combinational.
- P_RData  out  32  load data, valid when P_RValid is high.
- P_RValid  out  1  load-completion pulse.
- L_Req, L_Write, L_Addr[32], L_WData[32], L_Width[2]  in  loader request; same semantics as the P_* inputs.
- L_Done  out  1  loader access-completion pulse (write or read).
- L_RData  out  32  loader read data, valid when L_Done is high and the access is a read.
- M_R_Enable  out  1  DataMemory read enable, registered.
- M_W_Enable  out  1  DataMemory write enable, registered.
- M_Addr  out  32  DataMemory address, registered.
- M_WData  out  32  DataMemory write data, registered.
- M_R_Width  out  2  DataMemory read width, registered.
- M_W_Width  out  2  DataMemory write width, registered.
- M_RData  in  32  DataMemory read data.

Behaviour:
- FSM states: IDLE, ISSUE, RD_WAIT.
- IDLE: at a clock edge with any request pending, select the winner, register its command into the M_* outputs and the owner register, then go to ISSUE. With no request pending, stay in IDLE.
- Arbitration:
  - P wins when P_Req is high, unless starve_cnt == STARVE_MAX and L_Req is high; then L wins.
  - Only L requesting: L wins.
  - starve_cnt increments, saturating at STARVE_MAX, on each IDLE arbitration edge where L_Req is high and P wins.
  - starve_cnt clears when L wins or when L_Req is low in IDLE.
- ISSUE (exactly one cycle):
  - Exactly one of M_W_Enable / M_R_Enable is high.
  - A write completes in this cycle: the owner's done signal is high (P_Stall low, or L_Done high). Next state is IDLE.
  - A read goes to RD_WAIT, with lat_cnt loaded to LAT-1.
- RD_WAIT:
  - M_R_Enable is low and the M_Addr/M_R_Width registers hold their value.
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0, the completion cycle occurs:
    - P owner: P_RValid = 1 and P_RData = M_RData.
    - L owner: L_Done = 1 and L_RData = M_RData.
  - After the completion cycle, next state is IDLE.
- For LAT = 1, RD_WAIT lasts one cycle: ISSUE in cycle n, completion in cycle n+1.
- P_Stall = P_Req & ~(P completion this cycle). P_Stall is therefore high from the request cycle through the cycle before completion, and low in the completion cycle.
- Timing, idle arbiter, LAT = 1:
  - P load requested in cycle 0: stalled in cycles 0–1, data in cycle 2.
  - P store requested in cycle 0: stalled in cycle 0, done in cycle 1.
- No back-to-back pipelining: one outstanding access; the next arbitration happens in the IDLE cycle after completion.
- Requests arriving while busy wait. The requester must hold its request and inputs stable. A request dropped before completion is illegal; the access still completes and still pulses its done signal.
- P_RData and L_RData are 0 when their valid/done signal is low.
- Simultaneous P_Req and L_Req in IDLE with starve_cnt < STARVE_MAX: P wins and starve_cnt increments.
- Reset (asserted asynchronously, including mid-operation):
  - State returns to IDLE; starve_cnt = 0; lat_cnt = 0.
  - All M_* outputs = 0.
  - P_RValid, L_Done, P_RData and L_RData = 0.
  - P_Stall follows P_Req.
  - Any in-flight access is abandoned with no done pulse.

Decomposition:
- Shared package (dmem_pkg): state encoding (IDLE = 2'd0, ISSUE = 2'd1, RD_WAIT = 2'd2), owner codes (OWN_P = 1'b0, OWN_L = 1'b1), width codes (BYTE, HALF, WORD) shared with DataMemory.
- One natural sub-module: dmem_starve_counter (saturating counter with clear and force-grant output).

Test Plan:
- P load only, LAT = 1, P_Addr = 0x10, memory[0x10] = 0xDEADBEEF, request in cycle 0 -> P_Stall = 1 in cycles 0–1; M_R_Enable = 1 in cycle 1; P_RValid = 1 and P_RData = 0xDEADBEEF in cycle 2; P_Stall = 0 in cycle 2.
- P store 0x12345678 to 0x20 -> M_W_Enable = 1, M_Addr = 0x20 in cycle 1; P_Stall = 0 in cycle 1; a following read of 0x20 returns 0x12345678.
- L_Req held high with P_Req high continuously, STARVE_MAX = 4 -> P wins 4 consecutive arbitrations, L wins the 5th (L_Done pulses); starve_cnt returns to 0.
- LAT = 3, L read of 0x40 -> ISSUE in cycle n, L_Done high only in cycle n+3 with L_RData = M_RData; no M_R_Enable in cycles n+1..n+3.
- Reset pulled low during RD_WAIT -> all M_* outputs = 0 immediately; no P_RValid or L_Done; after release, a fresh P load completes normally.
- Simultaneous P store and L store to the same address, starve_cnt = 0 -> P write issues first; L write issues in the following ISSUE slot; memory holds L_WData.
